// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states (TAG/TAG_WAIT only reached when the
//                 UART_ARB_TAG_EN build option is defined)
//   TAG_BASE    : base value of the per-frame source tag byte (0xF0 | src)
//   AB_SAT      : saturation value of the aborted-frame counter
//   sat_inc8    : saturating 8-bit increment
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    TAG_WAIT,
    LOAD,
    WAIT_BUSY,
    WAIT_READY,
    DONE
  } arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'hF0;
  localparam logic [7:0] AB_SAT   = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == AB_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first asserted request at
// or after ptr, wrapping at N.
//   req    in  N      request vector
//   ptr    in  IDX_W  index that has highest priority this round (< N)
//   onehot out N      one-hot of the winner, 0 when no request
//   idx    out IDX_W  index of the winner, 0 when no request
//   any    out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // cand[k] is the source index sitting k places after ptr (mod N).
  logic [IDX_W:0]   sum  [N];
  logic [IDX_W-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (IDX_W+1)'(N)) ?
                        IDX_W'(sum[gi] - (IDX_W+1)'(N)) : sum[gi][IDX_W-1:0];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N byte-stream sources. Arbitration is
// round-robin at frame granularity: the owner keeps the UART until its byte
// flagged last has been handed over. A watchdog drops an owner that leaves
// req_valid low for TIMEOUT cycles mid-frame.
//
// Build option: define UART_ARB_TAG_EN to prefix each frame with a tag byte
// (0xF0 | source index). Without it frames are forwarded byte-exact.
//
// Ports
//   clk             in   1    system clock
//   reset           in   1    asynchronous, active-low
//   req_valid       in   N    source i has a byte on req_data[8i+:8]
//   req_data        in   8N   byte per source
//   req_last        in   N    byte is the final byte of its frame
//   req_ack         out  N    one-cycle pulse: byte of source i accepted
//   uart_ready      in   1    high = transmitter idle
//   uart_clk_enable out  1    start transmit of uart_data (held until
//                             uart_ready falls)
//   uart_data       out  8    byte to transmit, holds between bytes
//   grant           out  N    one-hot current owner, 0 when idle
//   aborted_cnt     out  8    saturating count of watchdog-aborted frames
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  input  logic           uart_ready,
  output logic           uart_clk_enable,
  output logic [7:0]     uart_data,
  output logic [N-1:0]   grant,
  output logic [7:0]     aborted_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic             last_reg;
  logic [TO_W-1:0]  wd_cnt;

  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             cur_valid;
  logic             cur_last;
  logic [7:0]       cur_data;
  logic [IDX_W-1:0] next_ptr;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Current owner's request lines.
  assign cur_valid = req_valid[owner_idx];
  assign cur_last  = req_last[owner_idx];
  assign cur_data  = req_data[8*owner_idx +: 8];

  // After a frame ends (normally or by abort) priority moves past the owner.
  assign next_ptr = (owner_idx == IDX_W'(N - 1)) ? '0 : owner_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      owner_idx       <= '0;
      rr_ptr          <= '0;
      last_reg        <= 1'b0;
      wd_cnt          <= '0;
      req_ack         <= '0;
      uart_clk_enable <= 1'b0;
      uart_data       <= 8'h00;
      grant           <= '0;
      aborted_cnt     <= 8'h00;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (uart_ready && pick_any) begin
            grant     <= pick_onehot;
            owner_idx <= pick_idx;
            wd_cnt    <= '0;
`ifdef UART_ARB_TAG_EN
            state     <= TAG;
`else
            state     <= LOAD;
`endif
          end
        end

`ifdef UART_ARB_TAG_EN
        TAG: begin
          uart_data       <= TAG_BASE | 8'(owner_idx);
          uart_clk_enable <= 1'b1;
          state           <= TAG_WAIT;
        end

        // Enable still high: waiting for the transmitter to take the tag.
        // Enable low: waiting for it to finish. Watchdog is idle here.
        TAG_WAIT: begin
          if (uart_clk_enable) begin
            if (!uart_ready) begin
              uart_clk_enable <= 1'b0;
            end
          end else if (uart_ready) begin
            state <= LOAD;
          end
        end
`endif

        LOAD: begin
          if (cur_valid) begin
            uart_data       <= cur_data;
            last_reg        <= cur_last;
            req_ack         <= grant;
            uart_clk_enable <= 1'b1;
            wd_cnt          <= '0;
            state           <= WAIT_BUSY;
          end else if (wd_cnt == TO_W'(TIMEOUT - 1)) begin
            aborted_cnt <= sat_inc8(aborted_cnt);
            grant       <= '0;
            rr_ptr      <= next_ptr;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        WAIT_BUSY: begin
          if (!uart_ready) begin
            uart_clk_enable <= 1'b0;
            state           <= last_reg ? DONE : WAIT_READY;
          end
        end

        WAIT_READY: begin
          if (uart_ready) begin
            state <= LOAD;
          end
        end

        DONE: begin
          grant  <= '0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end

        default: begin
          grant           <= '0;
          uart_clk_enable <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
